// File: rtl/poly_mem_pkg.sv
// Shared definitions for the polynomial memory clients: transfer direction,
// streamer state encoding and the address bit-reversal helper.
package poly_mem_pkg;

  localparam logic DIR_LOAD = 1'b0;
  localparam logic DIR_DUMP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DUMP
  } stream_state_e;

  // Reverses the low `width` bits of value; upper bits are returned as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] value, input int unsigned width);
    logic [15:0] r;
    r = '0;
    for (int unsigned i = 0; i < width; i++) begin
      r[4'(i)] = value[4'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/poly_stream_fifo2.sv
// Two-entry registered FIFO buffering read data against output backpressure.
module poly_stream_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy,
  output logic         empty
);

  logic [W-1:0] slot [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head      = slot[rd_ptr];
  assign occupancy = count;
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/poly_bank_streamer.sv
// Command-driven bank loader/dumper for one poly_mem_subsystem port.
// Optional POLY_STREAM_BITREV_EN adds cmd_bitrev for bit-reversed addressing.
module poly_bank_streamer
  import poly_mem_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int N         = 256,
  parameter int W         = 16,
  parameter int ADDR_W    = $clog2(N),
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [BANK_W-1:0] cmd_bank,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
`ifdef POLY_STREAM_BITREV_EN
  input  logic              cmd_bitrev,
`endif
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BANK_W-1:0] mem_bank,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  input  logic [W-1:0]      mem_rdata,
  input  logic              mem_stall
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  stream_state_e     state, state_next;
  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;
  logic [ADDR_W:0]   out_q;
  logic              inflight_q;
  logic              done_q;
  logic              done_next;
  logic              cmd_fire;
  logic              mem_accept;
  logic              pop;
  logic              room;
  logic              fifo_empty;
  logic [1:0]        occupancy;
  logic [ADDR_W:0]   len_clamped;
  logic [ADDR_W-1:0] lin_addr;
  logic [ADDR_W-1:0] addr_sel;

  assign cmd_fire    = cmd_valid && rst_n && (state == ST_IDLE);
  assign len_clamped = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign lin_addr    = base_q + idx_q[ADDR_W-1:0];
  assign mem_accept  = mem_req && !mem_stall;
  assign pop         = m_valid && m_ready;
  assign m_valid     = !fifo_empty;
  assign done        = done_q;
  // Reads in flight plus buffered data, minus this cycle's pop, must fit in 2 slots.
  assign room = ({1'b0, occupancy} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

`ifdef POLY_STREAM_BITREV_EN
  logic        bitrev_q;
  logic [15:0] rev_addr;
  assign rev_addr = bitrev(16'(lin_addr), ADDR_W);
  assign addr_sel = bitrev_q ? rev_addr[ADDR_W-1:0] : lin_addr;
`else
  assign addr_sel = lin_addr;
`endif

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    cmd_ready  = 1'b0;
    s_ready    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_bank   = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      ST_IDLE: begin
        cmd_ready = rst_n;
        if (cmd_fire) begin
          if (len_clamped == '0) done_next = 1'b1;
          else state_next = (cmd_dir == DIR_DUMP) ? ST_DUMP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        mem_req   = s_valid && rst_n;
        mem_we    = 1'b1;
        mem_bank  = bank_q;
        mem_addr  = addr_sel;
        mem_wdata = s_data;
        s_ready   = !mem_stall && rst_n;
        if (mem_req && !mem_stall && (idx_q == len_q - CNT_ONE)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      ST_DUMP: begin
        mem_req  = rst_n && (idx_q < len_q) && room;
        mem_bank = bank_q;
        mem_addr = addr_sel;
        if (pop && (out_q == len_q - CNT_ONE)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef POLY_STREAM_BITREV_EN
      bitrev_q   <= 1'b0;
`endif
    end else begin
      done_q     <= done_next;
      inflight_q <= mem_accept && !mem_we;
      if (cmd_fire) begin
        bank_q   <= cmd_bank;
        base_q   <= cmd_base;
        len_q    <= len_clamped;
        idx_q    <= '0;
        out_q    <= '0;
`ifdef POLY_STREAM_BITREV_EN
        bitrev_q <= cmd_bitrev;
`endif
      end else begin
        if (mem_accept) idx_q <= idx_q + CNT_ONE;
        if (pop)        out_q <= out_q + CNT_ONE;
      end
    end
  end

  poly_stream_fifo2 #(.W(W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (cmd_fire),
    .push      (inflight_q),
    .push_data (mem_rdata),
    .pop       (pop),
    .head      (m_data),
    .occupancy (occupancy),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_poly_bank_streamer.sv
// Scoreboard bench for poly_bank_streamer with a behavioural memory port.
module tb_poly_bank_streamer;
  import poly_mem_pkg::*;

  localparam int N  = 256;
  localparam int W  = 16;
  localparam int AW = 8;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir, cmd_bitrev;
  logic [BW-1:0] cmd_bank;
  logic [AW-1:0] cmd_base;
  logic [AW:0]   cmd_len;
  logic          done;
  logic          s_valid, s_ready;
  logic [W-1:0]  s_data;
  logic          m_valid, m_ready;
  logic [W-1:0]  m_data;
  logic          mem_req, mem_we;
  logic [BW-1:0] mem_bank;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata, mem_rdata;
  logic          mem_stall;

  always #5 clk = ~clk;

  poly_bank_streamer #(.NUM_BANKS(4), .N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_bank  (cmd_bank),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
`ifdef POLY_STREAM_BITREV_EN
    .cmd_bitrev(cmd_bitrev),
`endif
    .done      (done),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_bank  (mem_bank),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall)
  );

  typedef struct packed {
    logic          we;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
  } mem_op_t;

  mem_op_t      exp_mem[$];
  logic [W-1:0] exp_beat[$];
  logic [W-1:0] mem [4][N];
  logic         mem_init;
  int           cyc = 0;
  int           errors = 0;
  int           checks = 0;
  int           stall_lo = -1;
  int           stall_hi = -1;
  logic         mr_toggle = 1'b0;
  logic [3:0]   mr_pat = 4'b1001;
  int           max_occ = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < N; a++) mem[b][a] <= W'(b * 1000 + a);
    end else if (mem_req && !mem_stall) begin
      if (mem_we) mem[mem_bank][mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_bank][mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Backpressure/stall driver controlled by window and toggle settings.
  initial begin
    mem_stall = 1'b0;
    m_ready   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mem_stall = (cyc >= stall_lo) && (cyc < stall_hi);
      m_ready   = mr_toggle ? mr_pat[2'(cyc % 4)] : 1'b1;
    end
  end

  // Monitor: compares every accepted memory access and output beat.
  initial begin
    logic    prev_stall;
    mem_op_t prev_op, op, e;
    logic [W-1:0] eb;
    prev_stall = 1'b0;
    prev_op    = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        op = {mem_we, mem_bank, mem_addr, mem_wdata};
        if (prev_stall) begin
          chk("stall_hold_req", 32'(mem_req), 1);
          chk("stall_hold_op", 32'(op), 32'(prev_op));
        end
        if (mem_req && !mem_stall) begin
          if (exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem: got access addr=%0d we=%0d required none", mem_addr, mem_we);
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e.we));
            chk("mem_bank", 32'(mem_bank), 32'(e.bank));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          end
        end
        prev_stall = mem_req && mem_stall;
        prev_op    = op;
        if (m_valid && m_ready) begin
          if (exp_beat.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got %0d required none", m_data);
          end else begin
            eb = exp_beat.pop_front();
            chk("m_data", 32'(m_data), 32'(eb));
          end
        end
        if (int'(dut.u_fifo.occupancy) > max_occ) max_occ = int'(dut.u_fifo.occupancy);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic dir, input logic [BW-1:0] bank, input logic [AW-1:0] base,
                          input logic [AW:0] len, input logic br, input int stall_rel, output int a);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_bank = bank; cmd_base = base; cmd_len = len; cmd_bitrev = br;
    @(negedge clk);
    chk("cmd_ready", 32'(cmd_ready), 1);
    a = cyc;
    if (stall_rel >= 0) begin
      stall_lo = a + stall_rel;
      stall_hi = a + stall_rel + 3;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int got;
    got = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done) begin
        got = cyc;
        break;
      end
    end
    if (got < 0) begin
      checks++; errors++;
      $display("FAIL %s: got no done within 600 cycles required done", name);
    end else begin
      if (exp_cyc >= 0) chk(name, 32'(got), 32'(exp_cyc));
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input logic [BW-1:0] bank, input logic [AW-1:0] base, input int len,
                          input int mul, input int add, input int stop, input logic br,
                          input int done_off);
    int n, k, a;
    logic hs;
    logic [AW-1:0] ad;
    n = (len < stop) ? len : stop;
    for (int i = 0; i < n; i++) begin
      ad = AW'(int'(base) + i);
      if (br) ad = rev8(ad);
      exp_mem.push_back({1'b1, bank, ad, W'(i * mul + add)});
    end
    send_cmd(DIR_LOAD, bank, base, (AW+1)'(len), br, -1, a);
    k = 0;
    s_valid = 1'b1;
    s_data  = W'(add);
    for (int t = 0; t < 2000 && k < n; t++) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        k++;
        s_data = W'(k * mul + add);
      end
    end
    s_valid = 1'b0;
    if (k < n) begin
      checks++; errors++;
      $display("FAIL load_stream: got %0d beats required %0d", k, n);
    end
    if (stop >= len) wait_done("load_done", (done_off >= 0) ? a + done_off : -1);
  endtask

  task automatic run_dump(input logic [BW-1:0] bank, input logic [AW-1:0] base, input int len,
                          input int stall_rel, input int done_off);
    int a;
    for (int i = 0; i < len; i++)
      exp_mem.push_back({1'b0, bank, AW'(int'(base) + i), W'(0)});
    send_cmd(DIR_DUMP, bank, base, (AW+1)'(len), 1'b0, stall_rel, a);
    wait_done("dump_done", (done_off >= 0) ? a + done_off : -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int a;
    rst_n = 1'b0; mem_init = 1'b1;
    cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_bank = '0; cmd_base = '0; cmd_len = '0; cmd_bitrev = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; mem_init = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;

    // LOAD bank 2 with i*3+7, then dump it back.
    run_load(2, 0, 32, 3, 7, 1000, 1'b0, 33);
    for (int i = 0; i < 32; i++) exp_beat.push_back(W'(i * 3 + 7));
    run_dump(2, 0, 32, -1, 35);

    // Wrapping dump: addresses 250..255, 0..3 of bank 1.
    for (int i = 0; i < 10; i++) exp_beat.push_back(W'(1000 + ((250 + i) % 256)));
    run_dump(1, 250, 10, -1, 13);

    // Three stall cycles mid-transfer delay done by three.
    for (int i = 0; i < 16; i++) exp_beat.push_back(W'(16 + i));
    run_dump(0, 16, 16, 5, 22);

    // Output backpressure 1-0-0-1.
    mr_toggle = 1'b1;
    for (int i = 0; i < 8; i++) exp_beat.push_back(W'(3100 + i));
    run_dump(3, 100, 8, -1, -1);
    mr_toggle = 1'b0;
    chk("fifo_max_occ_le2", 32'(max_occ <= 2), 1);

    // Zero-length command.
    s_valid = 1'b1;
    send_cmd(DIR_LOAD, 1, 5, 0, 1'b0, -1, a);
    chk("len0_mem_req", 32'(mem_req), 0);
    wait_done("len0_done", a + 1);
    s_valid = 1'b0;

    // Reset in the middle of a LOAD after 5 writes.
    run_load(3, 0, 20, 1, 100, 5, 1'b0, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_s_ready", 32'(s_ready), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 0);
    chk("abort_m_valid", 32'(m_valid), 0);
    chk("abort_done", 32'(done), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready_after", 32'(cmd_ready), 1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) exp_beat.push_back(W'(100 + i));
    exp_beat.push_back(W'(3005));
    run_dump(3, 0, 6, -1, 9);

`ifdef POLY_STREAM_BITREV_EN
    run_load(0, 0, 256, 1, 0, 1000, 1'b1, 257);
    for (int i = 0; i < 256; i++) exp_beat.push_back(W'(rev8(8'(i))));
    run_dump(0, 0, 256, -1, 259);
`endif

    chk("exp_mem_drained", 32'(exp_mem.size()), 0);
    chk("exp_beat_drained", 32'(exp_beat.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/poly_bank_streamer.md
# poly_bank_streamer

Client-side initiator for one port of `poly_mem_subsystem`, the same req/bank/we/addr/wdata/rdata/stall port shape used by the NTT and pack/unpack engines. It executes single commands that either load a valid/ready coefficient stream into a polynomial bank or dump a bank out to a valid/ready stream. It honours arbiter stalls and buffers read data across output backpressure. It sits between the pack/unpack datapath and the `pu_*` port of the memory subsystem.

## Interface
- `NUM_BANKS`, 4, number of polynomial banks
- `N`, 256, coefficients per bank
- `W`, 16, coefficient width
- `ADDR_W`, `$clog2(N)`, coefficient address width
- `BANK_W`, `$clog2(NUM_BANKS)`, bank select width

Ports:
- `clk` in 1: single clock
- `rst_n` in 1: reset, synchronous, active-low
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_dir` in 1: 0 = LOAD (stream to bank), 1 = DUMP (bank to stream)
- `cmd_bank` in BANK_W: target bank
- `cmd_base` in ADDR_W: start address
- `cmd_len` in ADDR_W+1: coefficient count, 0..N
- `done` out 1: one-cycle pulse when a command completes
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in W: LOAD input stream
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out W: DUMP output stream
- `mem_req`, `mem_we` out 1; `mem_bank` out BANK_W; `mem_addr` out ADDR_W; `mem_wdata` out W: memory request
- `mem_rdata` in W: read data, valid the cycle after an accepted read
- `mem_stall` in 1: request not accepted this cycle

## Operation
- States: IDLE, LOAD, DUMP.
- `cmd_ready` is 1 only in IDLE. A command is accepted on `cmd_valid && cmd_ready`, and the controller latches bank, base, len and dir at acceptance.
- An accepted command with `cmd_len == 0` pulses `done` in the next cycle, stays in IDLE, and produces no memory traffic.
- Address of element i is `(cmd_base + i) mod N`, wrapping at N. `cmd_len > N` is clamped to N.
- An access is accepted when `mem_req && !mem_stall`.
- While `mem_req && mem_stall`, the request outputs are held stable.
- LOAD:
  - `mem_req = s_valid`, `mem_we = 1`, `mem_wdata = s_data`, `s_ready = !mem_stall`.
  - The index advances on each accepted write.
  - After the last accepted write, the block returns to IDLE and pulses `done` the next cycle.
- DUMP:
  - `mem_we = 0`.
  - A read is issued while `issued < len` and `occupancy + inflight - pop < 2`, where pop is `m_valid && m_ready` in the same cycle.
  - `mem_rdata` is written into a 2-entry FIFO the cycle after read acceptance.
  - `m_valid` is the FIFO's non-empty flag; `m_data` is the FIFO head.
  - After the len-th output beat, the block returns to IDLE and pulses `done` the next cycle.
- Reset mid-command aborts the command: the FIFO is flushed, counters clear, no `done` pulse is produced, and in-flight read data is discarded.

## Timing
- Reset values:
  - `cmd_ready = 0` while `rst_n = 0`, and 1 from the first cycle after reset.
  - All other outputs are 0.
- LOAD, no stall, `s_valid` held high:
  - `mem_req` is high from cycle A+1, where A is the acceptance cycle.
  - One write per cycle.
  - `done` asserts at cycle A+len+1.
- DUMP, no stall, `m_ready` high:
  - First read at A+1, first `m_valid` at A+3.
  - Sustains one beat per cycle.
  - `done` asserts at A+len+3.
- Each stall cycle delays subsequent traffic by exactly one cycle. `m_ready` low throttles reads with no data loss.

## Configuration
- `POLY_STREAM_BITREV_EN`:
  - Defined: adds input port `cmd_bitrev` (1 bit), latched at acceptance. When it is 1, `mem_addr = bitrev_ADDR_W((cmd_base + i) mod N)`, giving NTT-order transfers.
  - Undefined: no `cmd_bitrev` port; addressing is linear only.

## Structure
- Shared package `poly_mem_pkg`:
  - `DIR_LOAD` / `DIR_DUMP` constants.
  - State enum `stream_state_e`.
  - `bitrev` function.
- Sub-module `poly_stream_fifo2`: 2-entry registered FIFO with push, pop, `occupancy`, `empty` and `flush`.

## Test plan
- LOAD bank 2, base 0, len 32, data `i*3+7`, no stall: 32 consecutive writes to addresses 0..31; `done` asserts at A+33; DUMP of the same range returns 7, 10, …, 100.
- DUMP bank 1, base 250, len 10: addresses 250..255 then 0..3 (wrap-around); 10 beats in order.
- DUMP len 16 with `mem_stall` forced high for 3 cycles mid-transfer: address held stable while stalled; no duplicated or missing beats; `done` delayed by 3 cycles.
- DUMP len 8 with `m_ready` toggling 1-0-0-1: FIFO never exceeds 2 entries; all 8 values correct.
- `cmd_len = 0`: `done` asserts at A+1 with no `mem_req`. `rst_n` dropped mid-LOAD: outputs zero, no `done`, `cmd_ready` asserts after reset.
- With `POLY_STREAM_BITREV_EN` defined: LOAD len 256 with `cmd_bitrev = 1`, then linear DUMP: location `bitrev(i)` holds element i (element 1 at address 128).
